// File: rtl/rx_pkg.sv
// Shared constants for the receive character decoder: control codes and FIFO marker words.
package rx_pkg;

  localparam logic [1:0] CC_FCT = 2'b00;
  localparam logic [1:0] CC_EOP = 2'b01;
  localparam logic [1:0] CC_EEP = 2'b10;
  localparam logic [1:0] CC_ESC = 2'b11;

  localparam logic [8:0] MARK_EOP = 9'h100;
  localparam logic [8:0] MARK_EEP = 9'h101;

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_ESC_PEND = 1'b1
  } dec_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead circular FIFO of 9-bit entries; a write into a full FIFO is accepted only with a same-cycle pop.
module rx_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       wr_en_i,
  input  logic [8:0] wr_data_i,
  output logic       full_o,
  input  logic       rd_en_i,
  output logic [8:0] rd_data_o,
  output logic       rd_valid_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH_LOG2'(0) + (DEPTH_LOG2+1)'(DEPTH);

  logic [8:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty;
  logic                  pop;
  logic                  push;

  assign empty      = (count_q == '0);
  assign full_o     = (count_q == DEPTH_CNT);
  assign pop        = rd_en_i && !empty;
  assign push       = wr_en_i && (!full_o || pop);
  assign rd_valid_o = !empty;
  // Head is forced to zero while empty so the output is defined out of reset.
  assign rd_data_o  = empty ? 9'h000 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/rx_token_decoder.sv
// Resolves ESC sequences into link tokens and queues data bytes and packet markers for the packet layer.
module rx_token_decoder
  import rx_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       rxClk,
  input  logic       rxReset,
  input  logic [7:0] q,
  input  logic       nchar,
  input  logic       lchar,
  input  logic       parityError,
  output logic       gotNull,
  output logic       gotFct,
  output logic       gotTime,
  output logic [7:0] timeOut,
  output logic       escError,
  output logic       parErr,
  output logic       overflow,
  output logic [8:0] rdData,
  output logic       rdValid,
  input  logic       rdReady
);

  dec_state_e state_q, state_d;
  logic       got_null_q, got_null_d;
  logic       got_fct_q, got_fct_d;
  logic       got_time_q, got_time_d;
  logic       esc_error_q, esc_error_d;
  logic       par_err_q, par_err_d;
  logic       overflow_q, overflow_d;
  logic [7:0] time_q, time_d;
  logic       fifo_wr;
  logic [8:0] fifo_wdata;
  logic       fifo_full;
  logic       bad_char;

  // Both strobes at once cannot be a legal character, so it is handled as a parity failure.
  assign bad_char = parityError || (nchar && lchar);

  always_comb begin
    state_d     = state_q;
    got_null_d  = 1'b0;
    got_fct_d   = 1'b0;
    got_time_d  = 1'b0;
    esc_error_d = 1'b0;
    par_err_d   = 1'b0;
    time_d      = time_q;
    fifo_wr     = 1'b0;
    fifo_wdata  = {1'b0, q};
    if (bad_char) begin
      par_err_d = 1'b1;
      state_d   = ST_NORMAL;
    end else if (nchar) begin
      if (state_q == ST_ESC_PEND) begin
        got_time_d = 1'b1;
        time_d     = q;
        state_d    = ST_NORMAL;
      end else begin
        fifo_wr = 1'b1;
      end
    end else if (lchar) begin
      if (state_q == ST_ESC_PEND) begin
        if (q[1:0] == CC_FCT) got_null_d = 1'b1;
        else                  esc_error_d = 1'b1;
        state_d = ST_NORMAL;
      end else begin
        case (q[1:0])
          CC_FCT: got_fct_d = 1'b1;
          CC_EOP: begin fifo_wr = 1'b1; fifo_wdata = MARK_EOP; end
          CC_EEP: begin fifo_wr = 1'b1; fifo_wdata = MARK_EEP; end
          default: state_d = ST_ESC_PEND;
        endcase
      end
    end
  end

  assign overflow_d = fifo_wr && fifo_full && !(rdReady && rdValid);

  always_ff @(posedge rxClk) begin
    if (rxReset) begin
      state_q     <= ST_NORMAL;
      got_null_q  <= 1'b0;
      got_fct_q   <= 1'b0;
      got_time_q  <= 1'b0;
      esc_error_q <= 1'b0;
      par_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
      time_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      got_null_q  <= got_null_d;
      got_fct_q   <= got_fct_d;
      got_time_q  <= got_time_d;
      esc_error_q <= esc_error_d;
      par_err_q   <= par_err_d;
      overflow_q  <= overflow_d;
      time_q      <= time_d;
    end
  end

  assign gotNull  = got_null_q;
  assign gotFct   = got_fct_q;
  assign gotTime  = got_time_q;
  assign escError = esc_error_q;
  assign parErr   = par_err_q;
  assign overflow = overflow_q;
  assign timeOut  = time_q;

  rx_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk_i      (rxClk),
    .srst_i     (rxReset),
    .wr_en_i    (fifo_wr),
    .wr_data_i  (fifo_wdata),
    .full_o     (fifo_full),
    .rd_en_i    (rdReady),
    .rd_data_o  (rdData),
    .rd_valid_o (rdValid)
  );

endmodule

// File: tb/tb_rx_token_decoder.sv
// Directed plus randomized checks of rx_token_decoder against a queue-based reference model.
module tb_rx_token_decoder;

  logic       rxClk = 1'b0;
  logic       rxReset = 1'b1;
  logic [7:0] q = 8'h00;
  logic       nchar = 1'b0;
  logic       lchar = 1'b0;
  logic       parityError = 1'b0;
  logic       gotNull, gotFct, gotTime, escError, parErr, overflow, rdValid;
  logic [7:0] timeOut;
  logic [8:0] rdData;
  logic       rdReady = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  logic [8:0] m_fifo[$];
  bit         m_esc = 0;
  logic [7:0] m_time = 8'h00;
  bit e_null, e_fct, e_time, e_esc, e_par, e_ovf;

  rx_token_decoder #(.DEPTH_LOG2(3)) dut (
    .rxClk(rxClk), .rxReset(rxReset), .q(q), .nchar(nchar), .lchar(lchar),
    .parityError(parityError), .gotNull(gotNull), .gotFct(gotFct), .gotTime(gotTime),
    .timeOut(timeOut), .escError(escError), .parErr(parErr), .overflow(overflow),
    .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady)
  );

  always #5 rxClk = ~rxClk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit nc, input bit lc, input bit pe,
                       input logic [7:0] qv, input bit rdy);
    int  size0;
    bit  pop, wr;
    logic [8:0] wd;
    rxReset = rst; nchar = nc; lchar = lc; parityError = pe; q = qv; rdReady = rdy;
    {e_null, e_fct, e_time, e_esc, e_par, e_ovf} = '0;
    wr = 0; wd = 9'h000;
    if (rst) begin
      m_fifo.delete(); m_esc = 0; m_time = 8'h00;
    end else begin
      size0 = m_fifo.size();
      pop = rdy && (size0 > 0);
      if (pe || (nc && lc)) begin
        e_par = 1; m_esc = 0;
      end else if (nc) begin
        if (m_esc) begin e_time = 1; m_time = qv; m_esc = 0; end
        else begin wr = 1; wd = {1'b0, qv}; end
      end else if (lc) begin
        if (m_esc) begin
          if (qv[1:0] == 2'd0) e_null = 1; else e_esc = 1;
          m_esc = 0;
        end else begin
          case (qv[1:0])
            2'd0: e_fct = 1;
            2'd1: begin wr = 1; wd = 9'h100; end
            2'd2: begin wr = 1; wd = 9'h101; end
            default: m_esc = 1;
          endcase
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (wr) begin
        if (size0 < 8 || pop) m_fifo.push_back(wd);
        else e_ovf = 1;
      end
    end
    @(posedge rxClk);
    #1;
    chk("gotNull", {8'h0, gotNull}, {8'h0, e_null});
    chk("gotFct", {8'h0, gotFct}, {8'h0, e_fct});
    chk("gotTime", {8'h0, gotTime}, {8'h0, e_time});
    chk("escError", {8'h0, escError}, {8'h0, e_esc});
    chk("parErr", {8'h0, parErr}, {8'h0, e_par});
    chk("overflow", {8'h0, overflow}, {8'h0, e_ovf});
    chk("timeOut", {1'b0, timeOut}, {1'b0, m_time});
    chk("rdValid", {8'h0, rdValid}, {8'h0, m_fifo.size() > 0});
    if (m_fifo.size() > 0) chk("rdData", rdData, m_fifo[0]);
    $display("txn rst=%0b n=%0b l=%0b pe=%0b q=%h rdy=%0b -> valid=%0b data=%h pulses=%0b%0b%0b%0b%0b%0b time=%h",
             rst, nc, lc, pe, qv, rdy, rdValid, rdData,
             gotNull, gotFct, gotTime, escError, parErr, overflow, timeOut);
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 0, 0, 8'h00, rdy);
  endtask

  initial begin
    int r;
    bit nc, lc, pe;
    cycle(1, 0, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 0, 8'h00, 0);
    chk("reset_rdData", rdData, 9'h000);
    chk("reset_timeOut", {1'b0, timeOut}, 9'h000);

    // ESC then FCT -> NULL
    cycle(0, 0, 1, 0, 8'h03, 0);
    cycle(0, 0, 1, 0, 8'h00, 0);
    chk("null_pulse", {8'h0, gotNull}, 9'h001);

    // data byte held, then EOP marker behind it
    cycle(0, 1, 0, 0, 8'h48, 0);
    chk("data_head", rdData, 9'h048);
    idle(0);
    cycle(0, 0, 1, 0, 8'h01, 0);
    chk("data_held", rdData, 9'h048);
    idle(1);
    chk("eop_head", rdData, 9'h100);
    idle(1);

    // time code
    cycle(0, 0, 1, 0, 8'h03, 0);
    cycle(0, 1, 0, 0, 8'h2A, 0);
    chk("time_val", {1'b0, timeOut}, 9'h02A);

    // ESC ESC -> error, then bare FCT
    cycle(0, 0, 1, 0, 8'h03, 0);
    cycle(0, 0, 1, 0, 8'h03, 0);
    chk("esc_err", {8'h0, escError}, 9'h001);
    cycle(0, 0, 1, 0, 8'h00, 0);
    chk("fct_after_err", {8'h0, gotFct}, 9'h001);

    // overflow on the ninth write, ordered drain
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 8'(i), 0);
    chk("ovf_pulse", {8'h0, overflow}, 9'h001);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", rdData, 9'(i));
      idle(1);
    end
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 8'(i), 0);
    cycle(0, 1, 0, 0, 8'h08, 1);
    chk("no_ovf_with_pop", {8'h0, overflow}, 9'h000);
    for (int i = 0; i < 8; i++) idle(1);

    // parity error while ESC pending
    cycle(0, 0, 1, 0, 8'h03, 0);
    cycle(0, 1, 0, 1, 8'h55, 0);
    chk("par_pulse", {8'h0, parErr}, 9'h001);

    // reset with entries queued
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 8'hA0 + 8'(i), 0);
    cycle(1, 0, 0, 0, 8'h00, 0);
    chk("reset_flush", {8'h0, rdValid}, 9'h000);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 99));
      nc = (r < 40);
      lc = (r >= 40 && r < 80) || (r >= 97);
      pe = (r >= 90 && r < 95);
      cycle(($urandom_range(0, 199) == 0), nc, lc, pe, 8'($urandom),
            ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rx_token_decoder.md
# rx_token_decoder

Character-level decoder directly downstream of `rx_top`. Consumes the one-cycle `nchar`/`lchar`/`parityError` strobes and `q` byte, resolves escape sequences into link tokens (NULL, FCT, time code), and buffers data bytes plus end-of-packet markers in a small FIFO for the packet layer. Token pulses go to the link state machine; the FIFO read side goes to the host or packet interface.

## Interface
- `DEPTH_LOG2`, 3: log2 of FIFO depth in entries (default 8 entries).
- `rxClk`  in  1  receive clock; all logic on its rising edge.
- `rxReset`  in  1  synchronous, active-high reset.
- `q`  in  8  character payload from `rx_top`; valid only when `nchar` or `lchar` is high.
- `nchar`  in  1  one-cycle strobe: `q` holds a data byte.
- `lchar`  in  1  one-cycle strobe: `q[1:0]` holds a control code (00 FCT, 01 EOP, 10 EEP, 11 ESC).
- `parityError`  in  1  one-cycle strobe: parity failure on the current character.
- `gotNull`  out  1  one-cycle pulse: ESC followed by FCT.
- `gotFct`  out  1  one-cycle pulse: bare FCT.
- `gotTime`  out  1  one-cycle pulse: ESC followed by a data byte.
- `timeOut`  out  8  time-code byte; updated with `gotTime`, held otherwise.
- `escError`  out  1  one-cycle pulse: ESC followed by EOP, EEP or ESC.
- `parErr`  out  1  one-cycle pulse: registered copy of `parityError`.
- `overflow`  out  1  one-cycle pulse: FIFO write dropped because the FIFO is full.
- `rdData`  out  9  FIFO head; bit 8 = marker flag; for a marker, `rdData[7:0]` = 0x00 (EOP) or 0x01 (EEP).
- `rdValid`  out  1  FIFO not empty.
- `rdReady`  in  1  consumer pops the head when high together with `rdValid`.

## Operation
- States: NORMAL and ESC_PEND; reset state is NORMAL.
- NORMAL: `nchar` writes {0,q}; `lchar` FCT pulses `gotFct`; EOP writes 0x100; EEP writes 0x101; ESC enters ESC_PEND.
- ESC_PEND: `lchar` FCT pulses `gotNull` and returns to NORMAL. `nchar` pulses `gotTime`, loads `timeOut`=q and returns to NORMAL. `lchar` EOP, EEP or ESC pulses `escError` and returns to NORMAL. ESC_PEND persists until the next strobe.
- `parityError` has priority. If `nchar`/`lchar` is also high in the same cycle, the character is discarded. The block pulses `parErr`, forces NORMAL and performs no FIFO write.
- `nchar` and `lchar` are never high together. If they are, treat the input as a parity error.
- FIFO: circular buffer, pointers `DEPTH_LOG2` bits with natural wrap, occupancy count `DEPTH_LOG2+1` bits.
- A write when full is dropped and pulses `overflow`, unless a pop occurs in the same cycle; in that case the write is accepted and `overflow` stays low.
- A simultaneous write and pop leaves the count unchanged. A pop when empty is ignored.
- Reset mid-operation: FIFO emptied, ESC_PEND discarded, all pulses cleared on the next edge.

## Timing
- Reset values: all pulse outputs 0, `timeOut`=0x00, `rdValid`=0, `rdData`=0x000.
- Token pulses (`gotNull`, `gotFct`, `gotTime`, `escError`, `parErr`, `overflow`) are registered. Each is high exactly one cycle, in the cycle after the input strobe edge.
- Write latency: a strobe sampled at edge N makes `rdValid` high after edge N when the FIFO was empty. `rdData` is show-ahead, so the head is valid while `rdValid` is high.
- A pop at edge N presents the next entry (or `rdValid`=0) after edge N.
- Back-to-back strobes on consecutive cycles are supported at full rate.

## Structure
- Shared package `rx_pkg`: control-code constants `CC_FCT`=2'b00, `CC_EOP`=2'b01, `CC_EEP`=2'b10, `CC_ESC`=2'b11; marker words `MARK_EOP`=9'h100, `MARK_EEP`=9'h101.
- One sub-module `rx_fifo` (parameter `DEPTH_LOG2`; write/data/full, read/data/valid). The escape state machine and pulse registers live in `rx_token_decoder`.

## Test plan
- ESC then FCT via `lchar` (q=0x03, then 0x00) -> single `gotNull` pulse; no `gotFct`; FIFO empty.
- `nchar` q=0x48, `rdReady`=0 -> `rdValid`=1, `rdData`=0x048 held. Then `lchar` q=0x01 -> after one pop `rdData`=0x100.
- ESC then `nchar` q=0x2A -> `gotTime` pulse, `timeOut`=0x2A; no FIFO write.
- ESC then ESC -> `escError` pulse, state NORMAL. Then `lchar` FCT -> `gotFct` (not `gotNull`).
- Nine `nchar` bytes 0x00..0x08, `rdReady`=0 -> eight accepted; `overflow` pulses on the ninth. Drain yields 0x000..0x007 in order. Repeat with `rdReady`=1 on the ninth write -> no overflow.
- `nchar` q=0x55 with `parityError`=1 while in ESC_PEND -> `parErr` pulse, no write, no `gotTime`. `rxReset` with 3 entries queued -> `rdValid`=0 next cycle.
